// File: rtl/dcache_miss_controller.sv
// -----------------------------------------------------------------------------
// dcache_miss_controller
//
// Sequencing FSM for a write-back, direct-mapped data cache sitting in front of
// a shared single-port main memory. Hits are served in the request cycle with
// no stall. A miss stalls the PC, runs an optional dirty-victim writeback (WB),
// then a line fill (FILL), then a single cache update (UPDATE). After that the
// held request replays in IDLE as a hit.
//
// Optional build macro: DCACHE_STATS_EN adds saturating hit/miss/writeback
// counters. The FSM behaves identically with or without the macro.
//
// Parameters:
//   MEM_LATENCY  cycles per main-memory access (1 .. 2**CNT_W)
//   CNT_W        width of the internal latency counter
//
// Ports:
//   clk_i               system clock, rising edge
//   reset_n_i           asynchronous active-low reset
//   req_valid_i         LW/SW present in the memory stage
//   req_write_i         1 = SW, 0 = LW (qualified by req_valid_i)
//   cache_hit_i         tag match and valid for the request address
//   cache_dirty_i       indexed (victim) line is dirty
//   pc_enable_o         1 = pipeline advances, 0 = stall
//   we_cache_o          cache line write strobe
//   cache_input_type_o  cache write data source: 0 = memory, 1 = store data
//   set_valid_o         valid bit written with we_cache_o
//   set_dirty_o         dirty bit written with we_cache_o
//   mem_re_o            memory read in progress
//   mem_we_o            memory write in progress
//   mem_addr_sel_o      0 = request address, 1 = victim tag and index
//   load_done_o         one-cycle pulse, LW data valid
//   busy_o              FSM not in IDLE
//   hit_count_o         (DCACHE_STATS_EN) non-replay hits
//   miss_count_o        (DCACHE_STATS_EN) detected misses
//   wb_count_o          (DCACHE_STATS_EN) victim writebacks started
// -----------------------------------------------------------------------------
module dcache_miss_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic        cache_hit_i,
    input  logic        cache_dirty_i,
    output logic        pc_enable_o,
    output logic        we_cache_o,
    output logic        cache_input_type_o,
    output logic        set_valid_o,
    output logic        set_dirty_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        load_done_o,
    output logic        busy_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o,
    output logic [31:0] wb_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_FILL   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    // Counter reload value: a transfer lasts cnt = LAT-1 down to 0 inclusive.
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pc_enable_s;
    logic we_cache_s;
    logic cache_input_type_s;
    logic set_valid_s;
    logic set_dirty_s;
    logic mem_re_s;
    logic mem_we_s;
    logic mem_addr_sel_s;
    logic load_done_s;
    logic busy_s;

    // State and latency counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and raw output decode.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        pc_enable_s        = 1'b1;
        we_cache_s         = 1'b0;
        cache_input_type_s = 1'b0;
        set_valid_s        = 1'b0;
        set_dirty_s        = 1'b0;
        mem_re_s           = 1'b0;
        mem_we_s           = 1'b0;
        mem_addr_sel_s     = 1'b0;
        load_done_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (cache_hit_i) begin
                        if (req_write_i) begin
                            // Store hit writes the line and marks it dirty.
                            we_cache_s         = 1'b1;
                            cache_input_type_s = 1'b1;
                            set_valid_s        = 1'b1;
                            set_dirty_s        = 1'b1;
                        end else begin
                            load_done_s = 1'b1;
                        end
                    end else begin
                        // Write-allocate: LW and SW misses take the same path.
                        pc_enable_s = 1'b0;
                        cnt_d       = LAT_M1;
                        if (cache_dirty_i) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                mem_we_s       = 1'b1;
                mem_addr_sel_s = 1'b1;
                pc_enable_s    = 1'b0;
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = LAT_M1;
                    state_d = ST_FILL;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FILL: begin
                mem_re_s    = 1'b1;
                pc_enable_s = 1'b0;
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_UPDATE: begin
                we_cache_s  = 1'b1;
                set_valid_s = 1'b1;
                pc_enable_s = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign busy_s = (state_q != ST_IDLE);

    // Reset gates the outputs directly so an in-flight memory transfer or a
    // hit-path write is cut off without waiting for a clock edge.
    assign pc_enable_o        = reset_n_i ? pc_enable_s : 1'b1;
    assign we_cache_o         = reset_n_i & we_cache_s;
    assign cache_input_type_o = reset_n_i & cache_input_type_s;
    assign set_valid_o        = reset_n_i & set_valid_s;
    assign set_dirty_o        = reset_n_i & set_dirty_s;
    assign mem_re_o           = reset_n_i & mem_re_s;
    assign mem_we_o           = reset_n_i & mem_we_s;
    assign mem_addr_sel_o     = reset_n_i & mem_addr_sel_s;
    assign load_done_o        = reset_n_i & load_done_s;
    assign busy_o             = reset_n_i & busy_s;

`ifdef DCACHE_STATS_EN
    // Saturating event counter increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        logic [31:0] res;
        if (en && (val != 32'hFFFF_FFFF)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic        replay_q, replay_d;
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        hit_ev_s, miss_ev_s, wb_ev_s;

    // The first IDLE cycle after UPDATE is the replay of the missed access;
    // it is not a new hit.
    assign hit_ev_s  = (state_q == ST_IDLE) & req_valid_i & cache_hit_i & ~replay_q;
    assign miss_ev_s = (state_q == ST_IDLE) & req_valid_i & ~cache_hit_i;
    assign wb_ev_s   = miss_ev_s & cache_dirty_i;

    // Replay flag: set by UPDATE, cleared by any IDLE cycle.
    always_comb begin
        replay_d = replay_q;
        case (state_q)
            ST_IDLE:   replay_d = 1'b0;
            ST_UPDATE: replay_d = 1'b1;
            default:   replay_d = replay_q;
        endcase
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            wb_cnt_q   <= 32'd0;
        end else begin
            replay_q   <= replay_d;
            hit_cnt_q  <= sat_inc(hit_cnt_q, hit_ev_s);
            miss_cnt_q <= sat_inc(miss_cnt_q, miss_ev_s);
            wb_cnt_q   <= sat_inc(wb_cnt_q, wb_ev_s);
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_miss_controller.sv
// -----------------------------------------------------------------------------
// Testbench for dcache_miss_controller. Two instances: MEM_LATENCY = 4 and
// MEM_LATENCY = 1. Expected per-cycle outputs come from a transaction-level
// model: a miss is a stall window of L+2 (clean) or 2L+2 (dirty) cycles split
// into writeback, fill and update phases, followed by a replay cycle.
// -----------------------------------------------------------------------------
module tb_dcache_miss_controller;

    localparam int L0 = 4;
    localparam int L1 = 1;

    // Output vector bit positions.
    localparam logic [9:0] B_PC   = 10'b10_0000_0000;
    localparam logic [9:0] B_WEC  = 10'b01_0000_0000;
    localparam logic [9:0] B_CIT  = 10'b00_1000_0000;
    localparam logic [9:0] B_SV   = 10'b00_0100_0000;
    localparam logic [9:0] B_SD   = 10'b00_0010_0000;
    localparam logic [9:0] B_RE   = 10'b00_0001_0000;
    localparam logic [9:0] B_MWE  = 10'b00_0000_1000;
    localparam logic [9:0] B_SEL  = 10'b00_0000_0100;
    localparam logic [9:0] B_LD   = 10'b00_0000_0010;
    localparam logic [9:0] B_BUSY = 10'b00_0000_0001;
    localparam logic [9:0] B_NONE = 10'b00_0000_0000;

    logic clk;
    logic reset_n;
    logic rv[2], rw[2], ht[2], dt[2];
    logic pc[2], wec[2], cit[2], sv[2], sd[2], re[2], mwe[2], sel[2], ld[2], bsy[2];
    logic [9:0] obs[2];
`ifdef DCACHE_STATS_EN
    logic [31:0] hc[2], mc[2], wc[2];
`endif

    int n_checks;
    int n_err;
    int m_hit[2], m_miss[2], m_wb[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dcache_miss_controller #(.MEM_LATENCY(L0), .CNT_W(8)) u_dut0 (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(rv[0]), .req_write_i(rw[0]), .cache_hit_i(ht[0]), .cache_dirty_i(dt[0]),
        .pc_enable_o(pc[0]), .we_cache_o(wec[0]), .cache_input_type_o(cit[0]),
        .set_valid_o(sv[0]), .set_dirty_o(sd[0]), .mem_re_o(re[0]), .mem_we_o(mwe[0]),
        .mem_addr_sel_o(sel[0]), .load_done_o(ld[0]), .busy_o(bsy[0])
`ifdef DCACHE_STATS_EN
        , .hit_count_o(hc[0]), .miss_count_o(mc[0]), .wb_count_o(wc[0])
`endif
    );

    dcache_miss_controller #(.MEM_LATENCY(L1), .CNT_W(8)) u_dut1 (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(rv[1]), .req_write_i(rw[1]), .cache_hit_i(ht[1]), .cache_dirty_i(dt[1]),
        .pc_enable_o(pc[1]), .we_cache_o(wec[1]), .cache_input_type_o(cit[1]),
        .set_valid_o(sv[1]), .set_dirty_o(sd[1]), .mem_re_o(re[1]), .mem_we_o(mwe[1]),
        .mem_addr_sel_o(sel[1]), .load_done_o(ld[1]), .busy_o(bsy[1])
`ifdef DCACHE_STATS_EN
        , .hit_count_o(hc[1]), .miss_count_o(mc[1]), .wb_count_o(wc[1])
`endif
    );

    assign obs[0] = {pc[0], wec[0], cit[0], sv[0], sd[0], re[0], mwe[0], sel[0], ld[0], bsy[0]};
    assign obs[1] = {pc[1], wec[1], cit[1], sv[1], sd[1], re[1], mwe[1], sel[1], ld[1], bsy[1]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance.
    task automatic cyc(input int u, input logic v, input logic w, input logic h,
                       input logic d, input logic [9:0] e, input string tag);
        rv[u] = v; rw[u] = w; ht[u] = h; dt[u] = d;
        @(negedge clk);
        chk($sformatf("u%0d %s", u, tag), {22'd0, obs[u]}, {22'd0, e});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] hit_vec(input logic w);
        return w ? (B_PC | B_WEC | B_CIT | B_SV | B_SD) : (B_PC | B_LD);
    endfunction

    // One access as seen from the pipeline. drop_at in 1..stall-1 withdraws
    // req_valid from that stall cycle onward; any other value keeps it held.
    task automatic txn(input int u, input int lat, input logic v, input logic w,
                       input logic h, input logic d, input int drop_at);
        int stall, fill0;
        logic live, vk;
        logic [9:0] e;
        if (!v) begin
            cyc(u, 1'b0, w, h, d, B_PC, "idle");
        end else if (h) begin
            cyc(u, 1'b1, w, 1'b1, d, hit_vec(w), "hit");
            m_hit[u]++;
        end else begin
            stall = d ? (2 * lat + 2) : (lat + 2);
            fill0 = d ? (lat + 1) : 1;
            live  = !(drop_at >= 1 && drop_at < stall);
            m_miss[u]++;
            if (d) m_wb[u]++;
            for (int k = 0; k < stall; k++) begin
                e = B_NONE;
                if (k > 0) e = e | B_BUSY;
                if (d && k >= 1 && k <= lat) e = e | B_MWE | B_SEL;
                if (k >= fill0 && k < fill0 + lat) e = e | B_RE;
                if (k == stall - 1) e = e | B_WEC | B_SV;
                vk = (k == 0) ? 1'b1 : !(drop_at >= 1 && k >= drop_at);
                cyc(u, vk, w, 1'b0, (k == 0) ? d : 1'($urandom_range(0, 1)), e,
                    $sformatf("miss d=%0b k=%0d", d, k));
            end
            cyc(u, live, w, 1'b1, 1'($urandom_range(0, 1)), live ? hit_vec(w) : B_PC, "replay");
        end
    endtask

    task automatic chk_stats(input int u, input string tag);
`ifdef DCACHE_STATS_EN
        chk($sformatf("u%0d %s hit_count", u, tag), hc[u], 32'(m_hit[u]));
        chk($sformatf("u%0d %s miss_count", u, tag), mc[u], 32'(m_miss[u]));
        chk($sformatf("u%0d %s wb_count", u, tag), wc[u], 32'(m_wb[u]));
`endif
    endtask

    task automatic clr_model();
        for (int u = 0; u < 2; u++) begin
            m_hit[u] = 0; m_miss[u] = 0; m_wb[u] = 0;
        end
    endtask

    initial begin
        int dr;
        n_checks = 0;
        n_err    = 0;
        clr_model();
        for (int u = 0; u < 2; u++) begin
            rv[u] = 1'b0; rw[u] = 1'b0; ht[u] = 1'b0; dt[u] = 1'b0;
        end
        reset_n = 1'b0;

        // Outputs are forced while reset is low, even with a live hit.
        rv[0] = 1'b1; ht[0] = 1'b1;
        #3;
        chk("reset outputs", {22'd0, obs[0]}, {22'd0, B_PC});
        rv[0] = 1'b0; ht[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, B_PC, "post-reset idle");
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, B_PC, "idle no req");
        chk_stats(0, "after reset");

        // Directed: LW hit, clean LW miss, dirty SW miss.
        txn(0, L0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        txn(0, L0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        txn(0, L0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        chk_stats(0, "directed");

        // Reset on the second FILL cycle aborts the read without a clock edge.
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, B_NONE, "abort detect");
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, B_RE | B_BUSY, "abort fill1");
        #2;
        chk("abort fill2 before reset", {22'd0, obs[0]}, {22'd0, B_RE | B_BUSY});
        reset_n = 1'b0;
        #1;
        chk("abort mem_re drop", {22'd0, obs[0]}, {22'd0, B_PC});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("abort held in reset", {22'd0, obs[0]}, {22'd0, B_PC});
        end
        @(negedge clk);
        rv[0] = 1'b0;
        reset_n = 1'b1;
        clr_model();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, B_PC, "abort idle after release");
        end
        chk_stats(0, "after abort");

        // Randomized traffic, L = 4.
        for (int i = 0; i < 60; i++) begin
            dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            txn(0, L0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dr);
        end
        chk_stats(0, "random");

        // L = 1: each memory phase lasts exactly one cycle.
        txn(1, L1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        txn(1, L1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        txn(1, L1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 25; i++) begin
            dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(1, L1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dr);
        end
        chk_stats(1, "random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
